obi_dma: RTL and testbench
==========================

# obi_dma

Word-granular memory-to-memory copy engine that acts as an additional OBI initiator on the system bus through one `ext_xbar_master_req_i`/`ext_xbar_master_resp_o` slot. It is programmed by the CPU as a register-interface responder hung off `ext_peripheral_slave_req_o`/`ext_peripheral_slave_resp_i`. Its done interrupt feeds one bit of `intr_vector_ext_i`.

## Interface
- `LEN_WIDTH`, default 16: width of the word-count register; maximum transfer is 2^LEN_WIDTH-1 words.
- `clk_i`, input, 1: the single clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `reg_req_i`, input, reg_req_t: configuration access (valid, write, wstrb, addr, wdata).
- `reg_rsp_o`, output, reg_rsp_t: ready, rdata, error.
- `obi_req_o`, output, obi_req_t: master request (req, we, be, addr, wdata).
- `obi_resp_i`, input, obi_resp_t: gnt, rvalid, rdata.
- `dma_done_intr_o`, output, 1: level interrupt; high while DONE is set.

## Operation
- Registers, decoded on addr[3:0]; addr[31:4] is ignored:
  - 0x0 SRC, 32 bits.
  - 0x4 DST, 32 bits.
  - 0x8 LEN in words, LEN_WIDTH bits, zero-extended on read.
  - 0xC CTRL/STATUS.
- CTRL/STATUS write: bit0=1 means START; bit1=1 means clear DONE.
- CTRL/STATUS read: bit0 BUSY, bit1 DONE, other bits 0.
- Any other offset (for example 0x10 aliasing to 0x0 is NOT an error; only non-word-aligned addr[1:0]≠0) returns error=1 and rdata=0, with no side effects.
- SRC and DST low 2 bits are forced to 0 on write. wstrb is ignored: whole-register writes only.
- Writes to SRC, DST or LEN while BUSY are acknowledged and discarded.
- START while BUSY is ignored.
- START while idle:
  - DONE is cleared.
  - Working copies src_q=SRC, dst_q=DST and cnt_q=LEN are loaded, and the FSM leaves IDLE.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - IDLE: on START with LEN≠0, go to RD_REQ. On START with LEN=0, set DONE and stay in IDLE with no OBI traffic.
  - RD_REQ: drive req=1, we=0, be=4'hF, addr=src_q. On gnt, go to RD_WAIT.
  - RD_WAIT: on rvalid, capture rdata into data_q and go to WR_REQ.
  - WR_REQ: drive req=1, we=1, be=4'hF, addr=dst_q, wdata=data_q. On gnt, go to WR_WAIT.
  - WR_WAIT: on rvalid, do src_q+=4, dst_q+=4, cnt_q-=1. If the new cnt_q is 0, set DONE and go to IDLE; otherwise go to RD_REQ.
- Only one outstanding OBI transaction at any time.
- Address and data rules while req=1:
  - addr, we, be and wdata are held stable until gnt.
  - req deasserts in the cycle after gnt.
- Address arithmetic is 32-bit modulo 2^32: a copy crossing 0xFFFFFFFC wraps to 0x0.
- BUSY = (state≠IDLE). SRC/DST/LEN readback shows the programmed values, not the working copies.
- DONE clears on a CTRL write with bit1=1 or on an accepted START. When START and clear are written together, START wins and DONE ends 0.

## Timing
- Reset values:
  - obi_req_o all fields 0; reg_rsp_o.rdata=0, error=0.
  - dma_done_intr_o=0; SRC, DST, LEN, DONE=0; state IDLE.
- reg_rsp_o.ready=1 always.
  - Read data is combinational from the registers in the same cycle as valid.
  - Register writes take effect at the next edge.
- START to first obi_req_o.req=1 is 1 cycle.
- Each word takes at least 4 cycles with a zero-wait slave (gnt in the request cycle, rvalid next cycle).
  - N words therefore take 4N cycles from first req to DONE set.
- dma_done_intr_o rises in the cycle after the last write's rvalid edge.
- Reset mid-transfer:
  - All outputs drop asynchronously to their reset values, even with a request outstanding.
  - Any late rvalid is ignored after reset.
- rvalid or gnt arriving in an unexpected state is ignored.

## Structure
- Package `obi_dma_reg_pkg` holds:
  - offsets SRC_OFFSET=4'h0, DST_OFFSET=4'h4, LEN_OFFSET=4'h8, CTRL_OFFSET=4'hC;
  - CTRL bit indices;
  - the FSM state enum.
- Sub-module `obi_dma_regs` contains the reg-interface decode, the registers and DONE. It exports start/clear pulses and register values, and takes busy/set_done inputs.
- The top level contains the FSM and datapath.

## Test plan
- SRC=0x1000, DST=0x2000, LEN=4, START with a zero-wait memory model:
  - four reads, then four writes interleaved (R,W,R,W,…) at 0x1000..0x100C and 0x2000..0x200C;
  - data copied;
  - DONE and intr high exactly 16 cycles after the first req.
- Slave with random gnt delay (0-5 cycles) and rvalid delay (1-5 cycles), LEN=64:
  - request fields stable until gnt;
  - never two outstanding transactions;
  - copy correct.
- LEN=0 START: no obi req ever asserted; DONE=1 one cycle later; BUSY read 0.
- While BUSY, write SRC=0xDEAD0000, write LEN, write START:
  - readbacks unchanged;
  - the transfer completes on the original addresses;
  - a read at offset 0x2 returns error=1.
- SRC=0xFFFFFFFC, LEN=2: second read at 0x00000000.
- rst_i asserted mid-RD_WAIT:
  - obi req 0 immediately;
  - all registers 0;
  - a later rvalid is ignored;
  - a fresh transfer after reset succeeds.

Source files
------------

// File: rtl/obi_dma_reg_pkg.sv
// obi_dma_reg_pkg
//   Shared definitions for the obi_dma copy engine: register offsets,
//   CTRL/STATUS bit positions, the copy FSM state encoding and the
//   register-interface / OBI bus structs used on the ports.
package obi_dma_reg_pkg;

  localparam logic [3:0] SRC_OFFSET  = 4'h0;
  localparam logic [3:0] DST_OFFSET  = 4'h4;
  localparam logic [3:0] LEN_OFFSET  = 4'h8;
  localparam logic [3:0] CTRL_OFFSET = 4'hC;

  // CTRL (write) bits
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;
  // STATUS (read) bits
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } dma_state_e;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_dma_regs.sv
// obi_dma_regs
//   Register-interface responder for the copy engine. Holds the programmed
//   SRC/DST/LEN values and the DONE flag, and turns CTRL writes into a
//   one-cycle start pulse.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   reg_req_i      configuration access (valid, write, wstrb, addr, wdata)
//   reg_rsp_o      always ready; combinational rdata, error on addr[1:0]!=0
//   busy_i         copy FSM is not idle (blocks SRC/DST/LEN writes and START)
//   set_done_i     copy finished (or zero-length START) this cycle
//   start_o        accepted START pulse
//   src_o, dst_o   programmed addresses (word aligned)
//   len_o          programmed word count
//   done_o         DONE flag
//
// Handshake: the responder is always ready, so every cycle with valid=1 is a
// complete transfer; reads return data in that same cycle, writes land at
// the following clock edge.
module obi_dma_regs
  import obi_dma_reg_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  reg_req_t             reg_req_i,
  output reg_rsp_t             reg_rsp_o,
  input  logic                 busy_i,
  input  logic                 set_done_i,
  output logic                 start_o,
  output logic [31:0]          src_o,
  output logic [31:0]          dst_o,
  output logic [LEN_WIDTH-1:0] len_o,
  output logic                 done_o
);

  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 done_q, done_d;

  logic       addr_err;
  logic       wr_en;
  logic       start;
  logic       clear;
  logic [3:0] offset;
  logic [31:0] len_ext;

  // Byte strobes and the upper address bits play no part in decoding.
  logic unused_req_bits;
  assign unused_req_bits = ^{reg_req_i.wstrb, reg_req_i.addr[31:4]};

  // addr[31:4] aliases onto the four registers; only misalignment is an error.
  assign offset   = {reg_req_i.addr[3:2], 2'b00};
  assign addr_err = (reg_req_i.addr[1:0] != 2'b00);
  assign wr_en    = reg_req_i.valid & reg_req_i.write & ~addr_err;

  always_comb begin
    len_ext                  = '0;
    len_ext[LEN_WIDTH-1:0]   = len_q;
  end

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    done_d = done_q;
    start  = 1'b0;
    clear  = 1'b0;
    if (wr_en) begin
      case (offset)
        SRC_OFFSET:  if (!busy_i) src_d = {reg_req_i.wdata[31:2], 2'b00};
        DST_OFFSET:  if (!busy_i) dst_d = {reg_req_i.wdata[31:2], 2'b00};
        LEN_OFFSET:  if (!busy_i) len_d = reg_req_i.wdata[LEN_WIDTH-1:0];
        CTRL_OFFSET: begin
          start = reg_req_i.wdata[CTRL_START_BIT] & ~busy_i;
          clear = reg_req_i.wdata[CTRL_CLEAR_BIT];
        end
        default: ;
      endcase
    end
    if (start || clear) done_d = 1'b0;
    // A zero-length START reports completion in the same edge it is accepted.
    if (set_done_i) done_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      len_q  <= len_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = 1'b0;
    reg_rsp_o.rdata = '0;
    if (reg_req_i.valid) begin
      if (addr_err) begin
        reg_rsp_o.error = 1'b1;
      end else if (!reg_req_i.write) begin
        case (offset)
          SRC_OFFSET:  reg_rsp_o.rdata = src_q;
          DST_OFFSET:  reg_rsp_o.rdata = dst_q;
          LEN_OFFSET:  reg_rsp_o.rdata = len_ext;
          CTRL_OFFSET: begin
            reg_rsp_o.rdata[STATUS_BUSY_BIT] = busy_i;
            reg_rsp_o.rdata[STATUS_DONE_BIT] = done_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign start_o = start;
  assign src_o   = src_q;
  assign dst_o   = dst_q;
  assign len_o   = len_q;
  assign done_o  = done_q;

endmodule

// File: rtl/obi_dma.sv
// obi_dma
//   Word-granular memory-to-memory copy engine. Programmed through a
//   register-interface responder (obi_dma_regs); moves LEN words from SRC to
//   DST as an OBI initiator, one read then one write per word, with at most
//   one transaction outstanding.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   reg_req_i/_rsp_o  configuration port
//   obi_req_o         OBI request (req, we, be, addr, wdata)
//   obi_resp_i        OBI response (gnt, rvalid, rdata)
//   dma_done_intr_o   level interrupt, high while DONE is set
//   state_o           current copy FSM state (debug)
//
// OBI handshake: a request is presented with req=1 and its fields held
// unchanged until the cycle gnt=1; req drops the cycle after. The response
// is the next rvalid=1 cycle. gnt/rvalid seen in any other state are ignored.
module obi_dma
  import obi_dma_reg_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  reg_req_t   reg_req_i,
  output reg_rsp_t   reg_rsp_o,
  output obi_req_t   obi_req_o,
  input  obi_resp_t  obi_resp_i,
  output logic       dma_done_intr_o,
  output dma_state_e state_o
);

  dma_state_e           state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          data_q, data_d;

  logic                 busy;
  logic                 set_done;
  logic                 start;
  logic [31:0]          reg_src;
  logic [31:0]          reg_dst;
  logic [LEN_WIDTH-1:0] reg_len;
  logic                 done;

  assign busy = (state_q != ST_IDLE);

  obi_dma_regs #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_regs (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .reg_req_i  (reg_req_i),
    .reg_rsp_o  (reg_rsp_o),
    .busy_i     (busy),
    .set_done_i (set_done),
    .start_o    (start),
    .src_o      (reg_src),
    .dst_o      (reg_dst),
    .len_o      (reg_len),
    .done_o     (done)
  );

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    set_done  = 1'b0;
    obi_req_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d = reg_src;
          dst_d = reg_dst;
          cnt_d = reg_len;
          if (reg_len == '0) set_done = 1'b1;
          else               state_d  = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        obi_req_o.req  = 1'b1;
        obi_req_o.be   = 4'hF;
        obi_req_o.addr = src_q;
        if (obi_resp_i.gnt) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (obi_resp_i.rvalid) begin
          data_d  = obi_resp_i.rdata;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        obi_req_o.req   = 1'b1;
        obi_req_o.we    = 1'b1;
        obi_req_o.be    = 4'hF;
        obi_req_o.addr  = dst_q;
        obi_req_o.wdata = data_q;
        if (obi_resp_i.gnt) state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (obi_resp_i.rvalid) begin
          // Addresses wrap naturally at 2^32.
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            set_done = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_RD_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign dma_done_intr_o = done;
  assign state_o         = state_q;

endmodule

// File: tb/tb_obi_dma.sv
// tb_obi_dma
//   Drives obi_dma through its register port against a randomized OBI
//   memory slave. A word-level model predicts the ordered list of OBI
//   transactions, the DONE level and BUSY, and is compared every cycle.
module tb_obi_dma;
  import obi_dma_reg_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  reg_req_t   reg_req = '0;
  reg_rsp_t   reg_rsp;
  obi_req_t   obi_req;
  obi_resp_t  obi_resp = '0;
  logic       intr;
  dma_state_e state;

  always #5 clk_i = ~clk_i;

  obi_dma #(.LEN_WIDTH(16)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .reg_req_i       (reg_req),
    .reg_rsp_o       (reg_rsp),
    .obi_req_o       (obi_req),
    .obi_resp_i      (obi_resp),
    .dma_done_intr_o (intr),
    .state_o         (state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // ---------------- memory + model state ----------------
  logic [31:0] mem [logic [31:0]];
  logic [68:0] exp_q[$];   // {we, be, addr, wdata} in predicted order
  logic [32:0] log_q[$];   // {we, addr} of granted transactions
  logic [31:0] m_src = '0, m_dst = '0;
  logic [15:0] m_len = '0;
  logic        m_busy = 1'b0, exp_done = 1'b0, fin_pending = 1'b0;
  int          n_grants = 0;

  int g_max = 0, rv_min = 1, rv_max = 1;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rd_mem(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_word(a);
  endfunction

  // Word-level effect of a register write on the model.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (a[1:0] != 2'b00) return;
    case (a[3:2])
      2'd0: if (!m_busy) m_src = {d[31:2], 2'b00};
      2'd1: if (!m_busy) m_dst = {d[31:2], 2'b00};
      2'd2: if (!m_busy) m_len = d[15:0];
      default: begin
        if (d[0] && !m_busy) begin
          exp_done = 1'b0;
          if (m_len == 16'd0) exp_done = 1'b1;
          else begin
            for (int i = 0; i < int'(m_len); i++) begin
              exp_q.push_back({1'b0, 4'hF, m_src + 32'(4 * i), 32'h0});
              exp_q.push_back({1'b1, 4'hF, m_dst + 32'(4 * i), rd_mem(m_src + 32'(4 * i))});
            end
            m_busy = 1'b1;
          end
        end else if (d[1]) begin
          exp_done = 1'b0;
        end
      end
    endcase
  endtask

  // ---------------- OBI slave + per-cycle compare ----------------
  logic        rv_pend = 1'b0, rv_we = 1'b0, rv_last = 1'b0, req_prev = 1'b0;
  logic [31:0] rv_addr = '0;
  int          rv_wait = 0, g_wait = 0;
  logic [68:0] cap = '0, cur, e;

  always @(negedge clk_i) begin
    obi_resp.gnt    = 1'b0;
    obi_resp.rvalid = 1'b0;
    obi_resp.rdata  = '0;
    if (rst_i) begin
      exp_q.delete();
      m_busy = 1'b0; exp_done = 1'b0; fin_pending = 1'b0;
      req_prev = 1'b0; rv_last = 1'b0;
    end else begin
      if (fin_pending) begin
        exp_done = 1'b1; m_busy = 1'b0; fin_pending = 1'b0;
      end
      check("intr_level", 32'(intr), 32'(exp_done));
      check("busy_state", 32'(state != ST_IDLE), 32'(m_busy));
    end
    if (rv_pend) begin
      if (!rst_i) check("one_outstanding", 32'(obi_req.req), 32'd0);
      rv_wait--;
      if (rv_wait == 0) begin
        obi_resp.rvalid = 1'b1;
        obi_resp.rdata  = rv_we ? 32'h0 : rd_mem(rv_addr);
        rv_pend = 1'b0;
        if (rv_last) fin_pending = 1'b1;
        rv_last = 1'b0;
      end
    end else if (!rst_i) begin
      cur = {obi_req.we, obi_req.be, obi_req.addr, obi_req.wdata};
      if (req_prev) check("req_held_until_gnt", 32'(obi_req.req), 32'd1);
      if (obi_req.req) begin
        if (!req_prev) begin
          g_wait = $urandom_range(g_max, 0);
          cap = cur;
        end else begin
          check("req_fields_stable", 32'(cur == cap), 32'd1);
        end
        if (g_wait == 0) begin
          obi_resp.gnt = 1'b1;
          req_prev = 1'b0;
          n_grants++;
          log_q.push_back({obi_req.we, obi_req.addr});
          if (exp_q.size() == 0) begin
            check("unexpected_req", 32'(obi_req.req), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("obi_we", 32'(obi_req.we), 32'(e[68]));
            check("obi_be", 32'(obi_req.be), 32'(e[67:64]));
            check("obi_addr", obi_req.addr, e[63:32]);
            if (obi_req.we) check("obi_wdata", obi_req.wdata, e[31:0]);
          end
          if (obi_req.we) mem[obi_req.addr] = obi_req.wdata;
          rv_pend = 1'b1;
          rv_wait = $urandom_range(rv_max, rv_min);
          rv_we   = obi_req.we;
          rv_addr = obi_req.addr;
          rv_last = obi_req.we && (exp_q.size() == 0);
        end else begin
          g_wait--;
          req_prev = 1'b1;
        end
      end else begin
        req_prev = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk_i); #1;
    reg_req.valid = 1'b1; reg_req.write = 1'b1; reg_req.wstrb = 4'hF;
    reg_req.addr = a; reg_req.wdata = d;
    #3;
    check("wr_error", 32'(reg_rsp.error), 32'(a[1:0] != 2'b00));
    @(posedge clk_i); #1;
    reg_req = '0;
    model_write(a, d);
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge clk_i); #1;
    reg_req.valid = 1'b1; reg_req.write = 1'b0; reg_req.addr = a;
    #3;
    d = reg_rsp.rdata; err = reg_rsp.error;
    #1 reg_req = '0;
  endtask

  task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic err;
    reg_read(a, d, err);
    check(name, d, exp);
    check({name, "_err"}, 32'(err), 32'(a[1:0] != 2'b00));
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((m_busy || fin_pending || exp_q.size() != 0) && k < budget) begin
      @(posedge clk_i); k++;
    end
    check("xfer_in_budget", 32'(k < budget), 32'd1);
    repeat (2) @(posedge clk_i);
  endtask

  task automatic check_copy(input string name, input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++)
      check(name, rd_mem(d + 32'(4 * i)), init_word(s + 32'(4 * i)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int n0;
    #2;
    check("rst_obi_req", 32'(obi_req.req), 32'd0);
    check("rst_obi_addr", obi_req.addr, 32'h0);
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_rsp_rdata", reg_rsp.rdata, 32'h0);
    check("rst_rsp_error", 32'(reg_rsp.error), 32'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check_read("rst_src", 32'h0, 32'h0);
    check_read("rst_dst", 32'h4, 32'h0);
    check_read("rst_len", 32'h8, 32'h0);
    check_read("rst_ctrl", 32'hC, 32'h0);

    // Zero-wait copy of 4 words: exact R,W interleave and 16-cycle latency.
    g_max = 0; rv_min = 1; rv_max = 1;
    log_q.delete();
    reg_write(32'h0, 32'h1000);
    reg_write(32'h4, 32'h2000);
    reg_write(32'h8, 32'd4);
    reg_write(32'hC, 32'h1);
    check("start_to_req", 32'(obi_req.req), 32'd1);
    k = 0;
    while (!intr && k < 100) begin @(posedge clk_i); #1; k++; end
    check("done_latency", 32'(k), 32'd16);
    wait_idle(200);
    check("log_size", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 4 && 2 * i + 1 < log_q.size(); i++) begin
      check("seq_rd_addr", log_q[2*i][31:0], 32'h1000 + 32'(4 * i));
      check("seq_rd_we", 32'(log_q[2*i][32]), 32'd0);
      check("seq_wr_addr", log_q[2*i+1][31:0], 32'h2000 + 32'(4 * i));
      check("seq_wr_we", 32'(log_q[2*i+1][32]), 32'd1);
    end
    check("copy_word0", rd_mem(32'h2000), 32'h5A5A1000);
    check("copy_word3", rd_mem(32'h200C), 32'h5A5A100C);
    check_read("ctrl_done", 32'hC, 32'h2);

    // Clear DONE.
    reg_write(32'hC, 32'h2);
    check("clear_done", 32'(intr), 32'd0);

    // Zero-length START: DONE next cycle, no bus traffic.
    n0 = n_grants;
    reg_write(32'h8, 32'd0);
    reg_write(32'hC, 32'h1);
    check("len0_done", 32'(intr), 32'd1);
    check_read("len0_ctrl", 32'hC, 32'h2);
    repeat (5) @(posedge clk_i);
    check("len0_no_req", 32'(n_grants), 32'(n0));

    // Writes while BUSY are discarded; misaligned access errors.
    g_max = 5; rv_min = 1; rv_max = 5;
    reg_write(32'h0, 32'h3000);
    reg_write(32'h4, 32'h4000);
    reg_write(32'h8, 32'd8);
    reg_write(32'hC, 32'h3);   // START together with clear
    check("start_clear_done", 32'(intr), 32'd0);
    repeat (4) @(posedge clk_i);
    reg_write(32'h0, 32'hDEAD0000);
    reg_write(32'h8, 32'd3);
    reg_write(32'hC, 32'h1);
    check_read("busy_src", 32'h0, 32'h3000);
    check_read("busy_len", 32'h8, 32'd8);
    check_read("busy_ctrl", 32'hC, 32'h1);
    check_read("misaligned", 32'h2, 32'h0);
    wait_idle(2000);
    check_copy("busy_copy", 32'h3000, 32'h4000, 8);
    check_read("alias_src", 32'h10, 32'h3000);
    check_read("alias_dst", 32'h14, 32'h4000);
    reg_write(32'h1, 32'hFFFF);
    check_read("misaligned_wr_no_effect", 32'h0, 32'h3000);

    // Address wrap at 2^32.
    g_max = 0; rv_min = 1; rv_max = 1;
    log_q.delete();
    reg_write(32'h0, 32'hFFFFFFFC);
    reg_write(32'h4, 32'h5000);
    reg_write(32'h8, 32'd2);
    reg_write(32'hC, 32'h1);
    wait_idle(200);
    check("wrap_log_size", 32'(log_q.size()), 32'd4);
    if (log_q.size() >= 3) check("wrap_second_rd", log_q[2][31:0], 32'h0);
    check("wrap_copy1", rd_mem(32'h5004), 32'h5A5A0000);

    // Random bus timing, 64 words; SRC low bits forced to zero.
    g_max = 5; rv_min = 1; rv_max = 5;
    reg_write(32'h0, 32'h00010003);
    reg_write(32'h4, 32'h00020000);
    reg_write(32'h8, 32'd64);
    check_read("src_aligned", 32'h0, 32'h00010000);
    reg_write(32'hC, 32'h1);
    wait_idle(5000);
    check_copy("rand_copy", 32'h10000, 32'h20000, 64);
    check("rand_done", 32'(intr), 32'd1);

    // Reset during RD_WAIT.
    g_max = 0; rv_min = 5; rv_max = 5;
    reg_write(32'h0, 32'h6000);
    reg_write(32'h4, 32'h7000);
    reg_write(32'h8, 32'd3);
    reg_write(32'hC, 32'h1);
    k = 0;
    while (state != ST_RD_WAIT && k < 50) begin @(posedge clk_i); #1; k++; end
    check("reach_rd_wait", 32'(state == ST_RD_WAIT), 32'd1);
    rst_i = 1'b1;
    m_src = '0; m_dst = '0; m_len = '0;
    #1;
    check("arst_req", 32'(obi_req.req), 32'd0);
    check("arst_state", 32'(state), 32'(ST_IDLE));
    check("arst_intr", 32'(intr), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (8) @(posedge clk_i);   // late rvalid arrives and must be ignored
    check("late_rvalid_idle", 32'(state), 32'(ST_IDLE));
    check_read("arst_src", 32'h0, 32'h0);
    check_read("arst_dst", 32'h4, 32'h0);
    check_read("arst_len", 32'h8, 32'h0);
    check_read("arst_ctrl", 32'hC, 32'h0);

    // Fresh transfer after reset.
    g_max = 2; rv_min = 1; rv_max = 3;
    reg_write(32'h0, 32'h6000);
    reg_write(32'h4, 32'h7100);
    reg_write(32'h8, 32'd3);
    reg_write(32'hC, 32'h1);
    wait_idle(500);
    check_copy("post_rst_copy", 32'h6000, 32'h7100, 3);
    check("post_rst_done", 32'(intr), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
